// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding, slice width and index-width helper for cla_seq_adder
package cla_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int SLICE_W = 8;
  function automatic int idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction
endpackage

// File: rtl/cla_seq_adder_cla.sv
// cla: 8-bit carry-lookahead adder cell (a + b + cin -> s, cout)
module cla (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] g, p;
  logic [8:0] c;
  logic       t;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    t = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = cin;
      for (int j = 0; j <= i; j++) c[i+1] = c[i+1] & p[j];
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    s = p ^ c[7:0];
    cout = c[8];
  end
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: byte-serial W-bit add/sub through one shared 8-bit CLA slice; CLA_SEQ_ACCUM_EN adds the acc port
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter  int BYTES = 4,
  localparam int W     = SLICE_W * BYTES
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
`ifdef CLA_SEQ_ACCUM_EN
  input  logic         acc,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow,
  output logic         zero
);
  localparam int IW = idx_w(BYTES);
  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d, res_q, res_d;
  logic [SLICE_W-1:0]   sum;
  logic                 c_out;
  logic                 acc_sel;
`ifdef CLA_SEQ_ACCUM_EN
  assign acc_sel = acc;
`else
  assign acc_sel = 1'b0;
`endif
  cla u_cla (
    .a   (a_q[SLICE_W*idx_q +: SLICE_W]),
    .b   (b_q[SLICE_W*idx_q +: SLICE_W]),
    .cin (carry_q),
    .s   (sum),
    .cout(c_out)
  );
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = res_q;
  assign cout      = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = acc_sel ? res_q : op_a;
        b_d     = sub ? ~op_b : op_b;
        carry_d = sub;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[SLICE_W*idx_q +: SLICE_W] = sum;
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(BYTES - 1)) begin
          state_d = DONE;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (sum[SLICE_W-1] != a_q[W-1]);
          zero_d  = ~|res_d;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
endmodule
